// File: rtl/ntt_out_collector.sv
// NTT output collector: captures one NTT result stream into an internal
// buffer and replays it in natural order. Each coefficient is reduced from
// [0, 2q) to [0, q). Even beats fill the lower half of the buffer and odd
// beats fill the upper half. The replay is a valid/ready stream whose
// out_index gives the coefficient position.
module ntt_out_collector #(
  parameter int DW        = 32,
  parameter int MAX_DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cap_start,
  input  logic [3:0]           ring_depth,
  input  logic [DW-1:0]        q,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [MAX_DEPTH-1:0] out_index,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int BUF_WORDS = 1 << MAX_DEPTH;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, FIN} state_t;

  state_t state, state_nxt;

  logic [DW-1:0]        mem [BUF_WORDS];
  logic [3:0]           depth_r;
  logic [DW-1:0]        q_r;
  logic [MAX_DEPTH-1:0] m;
  logic [MAX_DEPTH-1:0] last_idx;
  logic [MAX_DEPTH-1:0] half;
  logic [MAX_DEPTH-1:0] wr_addr;
  logic [MAX_DEPTH-1:0] rd_idx;
  logic [MAX_DEPTH:0]   n_full;
  logic [MAX_DEPTH:0]   rd_ptr;
  logic [DW-1:0]        red;
  logic [DW-1:0]        rd_data;
  logic                 depth_ok;
  logic                 accept;
  logic                 beat;
  logic                 last_beat;
  logic                 issue;
  logic                 out_load;
  logic                 rd_valid;
  logic                 xfer;
  logic                 last_xfer;

  assign depth_ok  = (ring_depth != 4'd0) && (32'(ring_depth) <= MAX_DEPTH);
  assign accept    = (state == IDLE) && cap_start && depth_ok;
  assign n_full    = (MAX_DEPTH+1)'(1) << depth_r;
  assign last_idx  = MAX_DEPTH'(n_full - 1'b1);
  assign half      = MAX_DEPTH'(n_full >> 1);
  assign beat      = (state == CAPTURE) && in_valid;
  assign last_beat = beat && (m == last_idx);
  assign red       = (in_data >= q_r) ? (in_data - q_r) : in_data;
  assign wr_addr   = (m >> 1) + (m[0] ? half : '0);
  assign xfer      = out_valid && out_ready;
  assign last_xfer = (state == DRAIN) && xfer && (out_index == last_idx);

  // The read stage holds one prefetched word. It refills only when it is
  // empty or its word moves into the output register on this edge. That
  // keeps full throughput without a skid buffer and holds the outputs
  // stable under backpressure.
  assign out_load  = rd_valid && (!out_valid || out_ready);
  assign issue     = (state == DRAIN) && (rd_ptr < n_full) && (!rd_valid || out_load);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = CAPTURE;
      CAPTURE: if (last_beat) state_nxt = DRAIN;
      DRAIN:   if (last_xfer) state_nxt = FIN;
      FIN:                    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State-derived status outputs
  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  // Capture bookkeeping, drain pipeline and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_r   <= '0;
      q_r       <= '0;
      m         <= '0;
      rd_ptr    <= '0;
      rd_idx    <= '0;
      rd_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      err       <= 1'b0;
    end else begin
      if ((state == IDLE) && cap_start) begin
        if (depth_ok) begin
          depth_r <= ring_depth;
          q_r     <= q;
          m       <= '0;
          rd_ptr  <= '0;
          err     <= 1'b0;
        end else begin
          err     <= 1'b1;
        end
      end
      if (beat) m <= m + 1'b1;
      if (((state == DRAIN) || (state == FIN)) && in_valid) err <= 1'b1;
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_idx <= rd_ptr[MAX_DEPTH-1:0];
      end
      if (issue)         rd_valid <= 1'b1;
      else if (out_load) rd_valid <= 1'b0;
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= rd_data;
        out_index <= rd_idx;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Buffer write port: reduced coefficient at its de-interleaved address
  always_ff @(posedge clk) begin
    if (beat && !reset) mem[wr_addr] <= red;
  end

  // Buffer synchronous read port feeding the prefetch stage
  always_ff @(posedge clk) begin
    if (issue) rd_data <= mem[rd_ptr[MAX_DEPTH-1:0]];
  end

endmodule

// File: tb/tb_ntt_out_collector.sv
// Self-checking bench for ntt_out_collector: random captures are checked
// against a natural-order reference built from the captured beats.
module tb_ntt_out_collector;

  localparam int DW = 32;
  localparam int MD = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          cap_start;
  logic [3:0]    ring_depth;
  logic [DW-1:0] q;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [MD-1:0] out_index;
  logic          busy;
  logic          done;
  logic          err;

  ntt_out_collector #(.DW(DW), .MAX_DEPTH(MD)) dut (
    .clk(clk), .reset(reset), .cap_start(cap_start), .ring_depth(ring_depth),
    .q(q), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference data
  logic [DW-1:0] beats     [1024];
  logic [DW-1:0] model_out [1024];
  logic [DW-1:0] got       [1024];
  int unsigned   exp_n = 0;
  int unsigned   ready_mode = 0;

  // Monitor-owned observations
  int unsigned   k_exp = 0;
  int unsigned   done_cnt = 0;
  int            first_valid_cyc = -1;
  int            last_xfer_cyc = 0;
  bit            prev_stall = 0;
  bit            prev_done = 0;
  logic [DW-1:0] prev_data;
  logic [MD-1:0] prev_idx;

  function automatic logic [DW-1:0] reduce(logic [DW-1:0] x, logic [DW-1:0] qv);
    return (x >= qv) ? x - qv : x;
  endfunction

  // Natural-order result: position k holds beat 2k (lower half) or 2(k-n/2)+1
  task automatic build_model(input int unsigned depth, input logic [DW-1:0] qv);
    int unsigned n;
    int unsigned src;
    n = 1 << depth;
    for (int unsigned k = 0; k < n; k++) begin
      src = (k < n / 2) ? 2 * k : 2 * (k - n / 2) + 1;
      model_out[k] = reduce(beats[src], qv);
    end
    exp_n = n;
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      k_exp = 0;
      first_valid_cyc = -1;
      prev_stall = 0;
      prev_done = 0;
    end else begin
      if (cap_start && !busy) begin
        k_exp = 0;
        first_valid_cyc = -1;
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_index", out_index, prev_idx);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        chk("xfer_within_n", k_exp < exp_n, 1);
        if (k_exp < exp_n) begin
          chk("out_index", out_index, k_exp);
          chk("out_data", out_data, model_out[k_exp]);
          got[k_exp] = out_data;
          k_exp++;
          last_xfer_cyc = cyc;
        end
      end
      if (done) begin
        chk("done_single_cycle", prev_done, 0);
        chk("done_without_valid", out_valid, 0);
        done_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
      prev_done  = done;
    end
  end

  // Downstream ready generator: 0 = always, 1 = random, 2 = 3-low/1-high
  initial begin
    int unsigned rcnt;
    rcnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = ((rcnt % 4) == 3);
        default: out_ready = 1'b1;
      endcase
      rcnt++;
    end
  end

  task automatic run_capture(input int unsigned depth, input logic [DW-1:0] qv,
                             input int unsigned mode, input bit gaps, input bit extra);
    int unsigned n;
    int unsigned d0;
    int          last_cyc;
    n = 1 << depth;
    build_model(depth, qv);
    ready_mode = mode;
    d0 = done_cnt;
    last_cyc = 0;
    @(posedge clk); #1;
    cap_start = 1'b1; ring_depth = 4'(depth); q = qv;
    @(posedge clk); #1;
    cap_start = 1'b0; ring_depth = 4'($urandom); q = $urandom;
    chk("busy_in_capture", busy, 1);
    chk("err_cleared_on_start", err, 0);
    for (int unsigned i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; in_data = $urandom;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1; in_data = beats[i];
      cap_start = (gaps && n >= 4 && i == n / 2);
      if (cap_start) ring_depth = 4'd1;
      last_cyc = int'(cyc);
      @(posedge clk); #1;
      cap_start = 1'b0;
    end
    in_valid = 1'b0;
    if (extra) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    for (int i = 0; i < 6000 && done_cnt == d0; i++) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("transfer_count", k_exp, n);
    chk("first_valid_latency", longint'(first_valid_cyc - last_cyc), 3);
    if (mode == 0) chk("no_bubbles", longint'(last_xfer_cyc - first_valid_cyc), n - 1);
    chk("err_after_capture", err, extra);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    logic [DW-1:0] qv;
    reset = 1'b1; cap_start = 1'b0; ring_depth = '0; q = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;

    // Beats while idle are ignored
    in_valid = 1'b1; in_data = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("idle_beat_busy", busy, 0);
    chk("idle_beat_err", err, 0);

    // Full ring, ascending beats
    for (int unsigned i = 0; i < 1024; i++) beats[i] = i;
    run_capture(10, 32'd12289, 0, 0, 0);
    chk("ramp_got5", got[5], 10);
    chk("ramp_got511", got[511], 1022);
    chk("ramp_got512", got[512], 1);
    chk("ramp_got1023", got[1023], 1023);

    // Reduction corners at depth 2
    beats[0] = 32'd12289; beats[1] = 32'd12288; beats[2] = 32'd24577; beats[3] = 32'd5;
    run_capture(2, 32'd12289, 0, 0, 0);
    chk("pin_model1", model_out[1], 12288);
    chk("corner_got0", got[0], 0);
    chk("corner_got1", got[1], 12288);
    chk("corner_got2", got[2], 12288);
    chk("corner_got3", got[3], 5);

    // Stray beat during drain sets err, data unaffected
    run_capture(2, 32'd12289, 0, 0, 1);

    // Depth 3 with 3-low/1-high backpressure
    qv = 32'd7681;
    for (int unsigned i = 0; i < 8; i++) beats[i] = $urandom_range(0, 2 * qv - 1);
    run_capture(3, qv, 2, 0, 0);

    // Bad depths set err and stay idle; a valid start clears it
    @(posedge clk); #1;
    cap_start = 1'b1; ring_depth = 4'd11;
    @(posedge clk); #1;
    cap_start = 1'b0;
    chk("bad_depth11_err", err, 1);
    chk("bad_depth11_busy", busy, 0);
    cap_start = 1'b1; ring_depth = 4'd0;
    @(posedge clk); #1;
    cap_start = 1'b0;
    chk("bad_depth0_busy", busy, 0);
    chk("bad_depth0_err", err, 1);
    for (int unsigned i = 0; i < 16; i++) beats[i] = $urandom_range(0, 2 * qv - 1);
    run_capture(4, qv, 1, 1, 0);

    // Reset mid-capture wins over cap_start and in_valid
    qv = 32'd12289;
    for (int unsigned i = 0; i < 1024; i++) beats[i] = $urandom_range(0, 2 * qv - 1);
    build_model(10, qv);
    @(posedge clk); #1;
    cap_start = 1'b1; ring_depth = 4'd10; q = qv;
    @(posedge clk); #1;
    cap_start = 1'b0;
    for (int unsigned i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      @(posedge clk); #1;
    end
    reset = 1'b1; cap_start = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cap_start = 1'b0; in_valid = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_out_index", out_index, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    run_capture(10, qv, 1, 1, 0);

    // Random rings
    for (int t = 0; t < 6; t++) begin
      int unsigned d;
      d  = $urandom_range(1, 10);
      qv = $urandom_range(2, 32'h7FFF_FFFF);
      for (int unsigned i = 0; i < (1 << d); i++) beats[i] = $urandom_range(0, 2 * qv - 1);
      run_capture(d, qv, $urandom_range(0, 1), 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ntt_out_collector.md
NTT_OUT_COLLECTOR -- requirements
Module: ntt_out_collector

Interface
REQ-001 SHALL have parameter DW, default 32, meaning coefficient word width.
REQ-002 SHALL have parameter MAX_DEPTH, default 10, meaning log2 of largest supported ring (1024).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cap_start, input, 1, one-cycle pulse that arms a capture (driven from NTT1024 done).
REQ-006 SHALL have port ring_depth, input, 4, log2 n; sampled on cap_start.
REQ-007 SHALL have port q, input, DW, modulus; sampled on cap_start.
REQ-008 SHALL have port in_valid, input, 1, qualifies in_data (one coefficient per beat).
REQ-009 SHALL have port in_data, input, DW, coefficient from NTT1024 dout0, range [0, 2q).
REQ-010 SHALL have port out_ready, input, 1, downstream accept.
REQ-011 SHALL have ports out_valid (output, 1), out_data (output, DW), and out_index (output, MAX_DEPTH), giving the natural-order result stream.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), and err (output, 1, sticky error).

Function
REQ-013 SHALL implement states IDLE, CAPTURE, DRAIN, FIN.
REQ-014 In IDLE, cap_start with 1 <= ring_depth <= MAX_DEPTH SHALL latch n = 1<<ring_depth and q, clear beat counter m and err, and enter CAPTURE next cycle.
REQ-015 cap_start with ring_depth 0 or > MAX_DEPTH SHALL set err and remain in IDLE.
REQ-016 in_valid in IDLE SHALL be ignored with no state change.
REQ-017 In CAPTURE, each in_valid beat SHALL store r = (in_data >= q) ? in_data - q : in_data, as an unsigned DW-bit compare and subtract.
REQ-018 Beat m SHALL be written to buffer address m>>1 when m is even, and to (m>>1) + n/2 when m is odd.
REQ-019 The beat with m = n-1 SHALL end CAPTURE, and DRAIN SHALL be entered on the next cycle.
REQ-020 Gaps (in_valid low) during CAPTURE SHALL be tolerated indefinitely.
REQ-021 DRAIN SHALL emit addresses 0..n-1 in order, with out_index equal to the address.
REQ-022 The first out_valid SHALL occur exactly 2 cycles after DRAIN entry, using a synchronous-read buffer plus an output register.
REQ-023 A transfer SHALL occur when out_valid && out_ready.
REQ-024 While out_valid && !out_ready, out_data and out_index SHALL hold stable.
REQ-025 With out_ready held high, DRAIN SHALL sustain one word per cycle, with no bubbles after the first.
REQ-026 After the transfer of index n-1, the block SHALL enter FIN: out_valid low, done high for exactly one cycle, then IDLE.
REQ-027 in_valid during DRAIN or FIN SHALL set err and discard the data; the buffer SHALL be unmodified.
REQ-028 cap_start outside IDLE SHALL be ignored.
REQ-029 busy SHALL be high in CAPTURE, DRAIN, and FIN.
REQ-030 err SHALL remain set until the next accepted cap_start or reset.
REQ-031 Buffer depth SHALL be 2^MAX_DEPTH words of DW bits.

Reset
REQ-032 reset SHALL force IDLE from any state, including mid-CAPTURE or mid-DRAIN, on the next edge.
REQ-033 reset SHALL clear m, the read pointer, out_valid, out_data, out_index, busy, done, and err to 0.
REQ-034 reset SHALL NOT clear buffer contents; stale data is never emitted, because a new capture rewrites all n locations.
REQ-035 reset SHALL take priority over cap_start and in_valid in the same cycle.

Verification
REQ-036 Scenario: q=12289, depth 10, in_data=m for m=0..1023, out_ready=1 -> out_data[k]=2k for k<512 and 2(k-512)+1 for k>=512; exactly 1024 transfers, then a done pulse.
REQ-037 Scenario: depth 2, beats 12289, 12288, 24577, 5 -> out (idx0=0, idx1=24577-12289=12288, idx2=12288, idx3=5).
REQ-038 Scenario: depth 3, out_ready toggled with a 3-low/1-high pattern -> 8 transfers in index order and no change of out_data while stalled.
REQ-039 Scenario: cap_start with ring_depth 11 -> err=1, busy stays 0; a following valid cap_start clears err.
REQ-040 Scenario: reset asserted after 300 beats of a depth-10 capture -> all outputs 0 next cycle; a fresh depth-10 capture then yields the correct full result.
REQ-041 Scenario: depth 2, an extra in_valid beat during DRAIN -> err=1 and the emitted data is unchanged.
